// File: rtl/nn_param_loader.sv
// Byte-command sequencer: decodes header/length/payload into one-hot SIPO shift enables,
// 2-bit parameter chunks, input bytes and timed nn_ce evaluation pulses.
module nn_param_loader #(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned LEN_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [1:0] param_data,
  output logic [7:0] input_data,
  output logic       fifo_w_ce,
  output logic       fifo_beta_shift_ce,
  output logic       fifo_minus_teta_ce,
  output logic       fifo_BN_factor_ce,
  output logic       fifo_BN_addend_ce,
  output logic       fifo_inputs_ce,
  output logic       nn_ce,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [2:0] TGT_INPUTS  = 3'd5;
  localparam logic [2:0] TGT_RUN     = 3'd6;
  localparam logic [2:0] TGT_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StStream, StRun} state_e;

  state_e           state_q;
  logic [2:0]       target_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       len_lo_q;
  logic [7:0]       shift_q;
  logic [1:0]       pend_q;
  logic [CNT_W-1:0] step_q;
  logic [5:0]       ce_q;
  logic [1:0]       param_data_q;
  logic [7:0]       input_data_q;
  logic             nn_ce_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             accept;
  logic [15:0]      len_full;
  logic [5:0]       tgt_onehot;

  assign accept     = cmd_valid && cmd_ready_q;
  assign len_full   = {cmd_data, len_lo_q};
  assign tgt_onehot = 6'b000001 << target_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      target_q     <= '0;
      rem_q        <= '0;
      len_lo_q     <= '0;
      shift_q      <= '0;
      pend_q       <= '0;
      step_q       <= '0;
      ce_q         <= '0;
      param_data_q <= '0;
      input_data_q <= '0;
      nn_ce_q      <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Enables and done are single-cycle unless re-asserted below
      ce_q    <= '0;
      nn_ce_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (cmd_data[2:0] == TGT_ILLEGAL) begin
              err_q <= 1'b1;
            end else begin
              target_q <= cmd_data[2:0];
              state_q  <= StLenLo;
              busy_q   <= 1'b1;
            end
          end
        end
        StLenLo: begin
          if (accept) begin
            len_lo_q <= cmd_data;
            state_q  <= StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            if (len_full == 16'd0) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (target_q == TGT_RUN) begin
              // First evaluation pulse coincides with the first RUN cycle
              state_q     <= StRun;
              cmd_ready_q <= 1'b0;
              nn_ce_q     <= 1'b1;
              rem_q       <= LEN_W'(len_full) - LEN_W'(1);
              step_q      <= '0;
            end else begin
              state_q <= StStream;
              rem_q   <= LEN_W'(len_full);
              pend_q  <= '0;
            end
          end
        end
        StStream: begin
          if (target_q == TGT_INPUTS) begin
            if (accept) begin
              ce_q         <= tgt_onehot;
              input_data_q <= cmd_data;
              rem_q        <= rem_q - LEN_W'(1);
              if (rem_q == LEN_W'(1)) cmd_ready_q <= 1'b0;
            end else if (rem_q == '0) begin
              state_q     <= StIdle;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else if (pend_q != 2'd0) begin
            ce_q         <= tgt_onehot;
            param_data_q <= shift_q[7:6];
            shift_q      <= {shift_q[5:0], 2'b00};
            pend_q       <= pend_q - 2'd1;
            // Reopen during the last chunk so the next byte follows without a gap
            cmd_ready_q  <= (pend_q == 2'd1) && (rem_q != '0);
          end else if (accept) begin
            ce_q         <= tgt_onehot;
            param_data_q <= cmd_data[7:6];
            shift_q      <= {cmd_data[5:0], 2'b00};
            pend_q       <= 2'd3;
            rem_q        <= rem_q - LEN_W'(1);
            cmd_ready_q  <= 1'b0;
          end else if (rem_q == '0) begin
            state_q     <= StIdle;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        StRun: begin
          if (rem_q == '0) begin
            state_q     <= StIdle;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (step_q == CNT_W'(STEP_CYCLES - 1)) begin
            nn_ce_q <= 1'b1;
            rem_q   <= rem_q - LEN_W'(1);
            step_q  <= '0;
          end else begin
            step_q <= step_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign param_data         = param_data_q;
  assign input_data         = input_data_q;
  assign fifo_w_ce          = ce_q[0];
  assign fifo_beta_shift_ce = ce_q[1];
  assign fifo_minus_teta_ce = ce_q[2];
  assign fifo_BN_factor_ce  = ce_q[3];
  assign fifo_BN_addend_ce  = ce_q[4];
  assign fifo_inputs_ce     = ce_q[5];
  assign nn_ce              = nn_ce_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule
